// File: rtl/ppf_pkg.sv
// Shared definitions for the polyphase filter bank output path: rounding modes,
// output clamp limits and the ceil-log2 helper used for pointer/counter widths.
package ppf_pkg;

  typedef enum logic {
    RND_HALF_UP    = 1'b0,
    RND_CONVERGENT = 1'b1
  } rnd_mode_e;

  localparam int     PPF_DOUT_WIDTH = 16;
  localparam longint SAT_MAX = (longint'(1) <<< (PPF_DOUT_WIDTH - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) <<< (PPF_DOUT_WIDTH - 1));

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ppf_out_stage_if.sv
// AXI4-Stream sample channel leaving the filter bank output stage.
interface ppf_out_stage_if #(
  parameter int DOUT_WIDTH = 16
);
  logic signed [DOUT_WIDTH-1:0] tdata;
  logic                         tvalid;
  logic                         tready;
  logic                         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ppf_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of 2.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module ppf_sync_fifo
  import ppf_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (!wr_ok && rd_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ppf_out_stage.sv
// Filter bank output stage: round by SHIFT, saturate to DOUT_WIDTH, frame-tag and
// buffer onto AXI4-Stream. Define PPF_OUT_CONVERGENT_EN for round-half-to-even.
module ppf_out_stage
  import ppf_pkg::*;
#(
  parameter int PIN_WIDTH   = 40,
  parameter int DOUT_WIDTH  = PPF_DOUT_WIDTH,
  parameter int SHIFT       = 15,
  parameter int NCHAN       = 64,
  parameter int FIFO_DEPTH  = 8,
  parameter int AFULL_LEVEL = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic signed [PIN_WIDTH-1:0] p_in,
  input  logic                        p_vld_i,
  ppf_out_stage_if.master             m_axis,
  output logic                        afull_o,
  output logic                        sat_o,
  output logic                        ovf_o
);
`ifdef PPF_OUT_CONVERGENT_EN
  localparam rnd_mode_e RND_MODE = RND_CONVERGENT;
`else
  localparam rnd_mode_e RND_MODE = RND_HALF_UP;
`endif
  localparam int CW = clog2(NCHAN);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam logic signed [PIN_WIDTH:0] HALF   = (PIN_WIDTH+1)'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [PIN_WIDTH:0] SAT_HI = (PIN_WIDTH+1)'(SAT_MAX);
  localparam logic signed [PIN_WIDTH:0] SAT_LO = (PIN_WIDTH+1)'(SAT_MIN);

  // One guard bit above PIN_WIDTH keeps the half-LSB addition from wrapping.
  function automatic logic signed [PIN_WIDTH:0] round_shift(input logic signed [PIN_WIDTH-1:0] x);
    logic signed [PIN_WIDTH:0] acc;
    acc = (PIN_WIDTH+1)'(x) + HALF;
    acc = acc >>> SHIFT;
    // On an exact tie the half-up result is k+1; clearing its LSB picks the even neighbour.
    if (RND_MODE == RND_CONVERGENT && x[SHIFT-1:0] == HALF[SHIFT-1:0]) acc[0] = 1'b0;
    return acc;
  endfunction

  function automatic logic sat_hit(input logic signed [PIN_WIDTH:0] r);
    return (r > SAT_HI) || (r < SAT_LO);
  endfunction

  function automatic logic signed [DOUT_WIDTH-1:0] saturate(input logic signed [PIN_WIDTH:0] r);
    if (r > SAT_HI)      return SAT_HI[DOUT_WIDTH-1:0];
    else if (r < SAT_LO) return SAT_LO[DOUT_WIDTH-1:0];
    else                 return r[DOUT_WIDTH-1:0];
  endfunction

  logic signed [PIN_WIDTH:0]    r_p1;
  logic                         vld_p1;
  logic signed [DOUT_WIDTH-1:0] d_p2;
  logic                         vld_p2;
  logic [CW-1:0]                chan;
  logic                         chan_last;
  logic [DOUT_WIDTH:0]          head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [AW:0]                  occ;
  logic [AW:0]                  occ_next;
  logic                         rd_en;
  logic                         wr_ok;

  // Stage 1: round
  always_ff @(posedge clk_i) begin
    r_p1 <= round_shift(p_in);
    if (rst_i) vld_p1 <= 1'b0;
    else       vld_p1 <= p_vld_i;
  end

  // Stage 2: saturate
  always_ff @(posedge clk_i) begin
    d_p2 <= saturate(r_p1);
    if (rst_i) begin
      vld_p2 <= 1'b0;
      sat_o  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1 && sat_hit(r_p1)) sat_o <= 1'b1;
    end
  end

  // FIFO write: channel tag, overflow and almost-full tracking
  assign chan_last = (chan == CW'(NCHAN - 1));
  assign rd_en     = m_axis.tvalid && m_axis.tready;
  assign wr_ok     = vld_p2 && (!fifo_full || rd_en);

  always_comb begin
    occ_next = occ;
    if (wr_ok && !rd_en)      occ_next = occ + 1'b1;
    else if (!wr_ok && rd_en) occ_next = occ - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chan    <= '0;
      ovf_o   <= 1'b0;
      afull_o <= 1'b0;
    end else begin
      if (vld_p2) chan <= chan_last ? '0 : chan + 1'b1;
      if (vld_p2 && fifo_full && !rd_en) ovf_o <= 1'b1;
      afull_o <= (occ_next >= (AW+1)'(AFULL_LEVEL));
    end
  end

  ppf_sync_fifo #(
    .WIDTH (DOUT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (vld_p2),
    .wr_data ({chan_last, d_p2}),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (occ)
  );

  // Head entry is forced to zero while empty so idle tdata/tlast read as 0.
  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : head[DOUT_WIDTH-1:0];
  assign m_axis.tlast  = !fifo_empty && head[DOUT_WIDTH];

endmodule

// File: tb/tb_ppf_out_stage.sv
// Directed bench for ppf_out_stage (NCHAN=4): rounding, saturation, framing,
// backpressure/overflow, full-with-read and reset mid-frame.
module tb_ppf_out_stage;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [39:0] p_in;
  logic               p_vld;
  logic               afull;
  logic               sat;
  logic               ovf;
  int                 checks = 0;
  int                 failures = 0;
  int                 beats;
  int                 first;
  int                 n;
  longint             rnd_in  [5];
  longint             rnd_exp [5];

  always #5 clk = ~clk;

  ppf_out_stage_if #(.DOUT_WIDTH(16)) axis ();

  ppf_out_stage #(.NCHAN(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .p_in    (p_in),
    .p_vld_i (p_vld),
    .m_axis  (axis),
    .afull_o (afull),
    .sat_o   (sat),
    .ovf_o   (ovf)
  );

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    p_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_single(input longint v, input longint exp, input string tag);
    int k;
    @(negedge clk);
    p_in  = 40'(v);
    p_vld = 1'b1;
    @(negedge clk);
    p_vld = 1'b0;
    k = 0;
    while (!axis.tvalid && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!axis.tvalid) check_val({tag, "_timeout"}, 0, 1);
    else              check_val(tag, axis.tdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; p_vld = 1'b0; p_in = '0; axis.tready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_tvalid", axis.tvalid, 0);
    check_val("rst_tdata",  axis.tdata, 0);
    check_val("rst_tlast",  axis.tlast, 0);
    check_val("rst_afull",  afull, 0);
    check_val("rst_sat",    sat, 0);
    check_val("rst_ovf",    ovf, 0);

    // Rounding
    rnd_in = '{16384, 49152, -16384, -49152, 40000};
`ifdef PPF_OUT_CONVERGENT_EN
    rnd_exp = '{0, 2, 0, -2, 1};
`else
    rnd_exp = '{1, 2, 0, -1, 1};
`endif
    axis.tready = 1'b1;
    for (int i = 0; i < 5; i++) send_single(rnd_in[i], rnd_exp[i], $sformatf("round%0d", i));
    check_val("round_no_sat", sat, 0);

    // Saturation
    send_single(64'sd1073709056, 32767, "sat_edge_max");
    send_single(-64'sd1073741824, -32768, "sat_edge_min");
    check_val("sat_edge_flag", sat, 0);
    send_single(64'sd2147483648, 32767, "sat_pos");
    check_val("sat_set", sat, 1);
    send_single(-64'sd2147483648, -32768, "sat_neg");
    send_single(64'sd1073725440, 32767, "sat_half_over");
    send_single(0, 0, "sat_zero");
    check_val("sat_sticky", sat, 1);
    do_reset();
    check_val("sat_cleared", sat, 0);

    // Framing: 8 back-to-back samples, tready high
    beats = 0; first = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (axis.tvalid) begin
        beats++;
        if (first < 0) first = i;
        check_val($sformatf("frame_data%0d", beats), axis.tdata, beats);
        check_val($sformatf("frame_last%0d", beats), axis.tlast, (beats % 4 == 0) ? 1 : 0);
      end
      if (i < 8) begin p_vld = 1'b1; p_in = 40'(longint'(i + 1) * 32768); end
      else p_vld = 1'b0;
    end
    check_val("frame_latency", first, 3);
    check_val("frame_beats", beats, 8);

    // Backpressure: 10 samples into an 8-deep FIFO
    do_reset();
    axis.tready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 5)  check_val("bp_afull_3w", afull, 0);
      if (i == 6)  check_val("bp_afull_4w", afull, 1);
      if (i == 10) check_val("bp_ovf_before", ovf, 0);
      if (i == 11) check_val("bp_ovf_after", ovf, 1);
      if (i < 10) begin p_vld = 1'b1; p_in = 40'(longint'(i) * 32768); end
      else p_vld = 1'b0;
    end
    check_val("bp_tvalid", axis.tvalid, 1);
    check_val("bp_head_hold", axis.tdata, 0);
    check_val("bp_afull_full", afull, 1);
    axis.tready = 1'b1;
    beats = 0; n = 0;
    while (axis.tvalid && n < 20) begin
      check_val($sformatf("bp_data%0d", beats), axis.tdata, beats);
      check_val($sformatf("bp_last%0d", beats), axis.tlast, (beats % 4 == 3) ? 1 : 0);
      beats++;
      @(negedge clk);
      n++;
    end
    check_val("bp_beats", beats, 8);
    check_val("bp_afull_drained", afull, 0);

    // Full FIFO with a write and a read in the same cycle
    do_reset();
    axis.tready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 11) check_val("fr_head", axis.tdata, 0);
      if (i == 13) begin
        check_val("fr_ovf", ovf, 0);
        check_val("fr_afull", afull, 1);
      end
      axis.tready = (i == 12);
      if (i < 8)        begin p_vld = 1'b1; p_in = 40'(longint'(i) * 32768); end
      else if (i == 10) begin p_vld = 1'b1; p_in = 40'(longint'(100) * 32768); end
      else p_vld = 1'b0;
    end
    axis.tready = 1'b1;
    beats = 0; n = 0;
    while (axis.tvalid && n < 20) begin
      check_val($sformatf("fr_data%0d", beats), axis.tdata, (beats < 7) ? beats + 1 : 100);
      check_val($sformatf("fr_last%0d", beats), axis.tlast, (beats == 2 || beats == 6) ? 1 : 0);
      beats++;
      @(negedge clk);
      n++;
    end
    check_val("fr_beats", beats, 8);
    check_val("fr_ovf_end", ovf, 0);

    // Reset mid-frame: 5 samples sent, 3 buffered
    do_reset();
    axis.tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) begin
        check_val("mr_sat_pre", sat, 1);
        check_val("mr_tvalid_pre", axis.tvalid, 1);
        rst = 1'b1;
      end
      if (i == 6) begin
        rst = 1'b0;
        check_val("mr_tvalid", axis.tvalid, 0);
        check_val("mr_tdata", axis.tdata, 0);
        check_val("mr_tlast", axis.tlast, 0);
        check_val("mr_afull", afull, 0);
        check_val("mr_sat", sat, 0);
        check_val("mr_ovf", ovf, 0);
      end
      if (i == 9) check_val("mr_flushed", axis.tvalid, 0);
      if (i == 0)     begin p_vld = 1'b1; p_in = 40'(64'sd2147483648); end
      else if (i < 5) begin p_vld = 1'b1; p_in = 40'(longint'(i) * 32768); end
      else p_vld = 1'b0;
    end
    axis.tready = 1'b1;
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axis.tvalid) begin
        beats++;
        check_val($sformatf("mr_last%0d", beats), axis.tlast, (beats == 4) ? 1 : 0);
      end
      if (i < 4) begin p_vld = 1'b1; p_in = 40'(longint'(i + 1) * 32768); end
      else p_vld = 1'b0;
    end
    check_val("mr_beats", beats, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
